// File: rtl/multicycle_control_unit_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the multi-cycle sequencer.
package multicycle_control_unit_pkg;

  localparam int unsigned INSTR_W_DEF  = 16;
  localparam int unsigned OPCODE_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned ALUOP_W_DEF  = 4;
  localparam int unsigned TIMEOUT_DEF  = 15;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_ADD  = 2;
  localparam int unsigned OP_SUB  = 3;
  localparam int unsigned OP_LD   = 4;
  localparam int unsigned OP_ST   = 5;
  localparam int unsigned OP_JMP  = 6;
  localparam int unsigned OP_BEQ  = 7;
  localparam int unsigned OP_HALT = 15;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt,
    StTrap
  } state_e;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction/data memory port between the sequencer (master) and the memory (slave).
interface multicycle_control_unit_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned ADDR_W  = 8
);

  logic               mem_req;
  logic               mem_we;
  logic               mem_sel_pc;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_sel_pc,
    output mem_addr,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_sel_pc,
    input  mem_addr,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational opcode classifier feeding the sequencer FSM.
module multicycle_control_unit_decoder
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALUOP_W  = 4
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [ALUOP_W-1:0]  alu_op_o,
  output logic                is_alu_o,
  output logic                is_ld_o,
  output logic                is_st_o,
  output logic                is_jmp_o,
  output logic                is_beq_o,
  output logic                is_halt_o,
  output logic                legal_o
);

  always_comb begin
    alu_op_o  = '0;
    is_alu_o  = 1'b0;
    is_ld_o   = 1'b0;
    is_st_o   = 1'b0;
    is_jmp_o  = 1'b0;
    is_beq_o  = 1'b0;
    is_halt_o = 1'b0;
    case (opcode_i)
      OPCODE_W'(OP_AND), OPCODE_W'(OP_OR), OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
        is_alu_o = 1'b1;
        alu_op_o = ALUOP_W'(opcode_i);
      end
      OPCODE_W'(OP_LD):   is_ld_o   = 1'b1;
      OPCODE_W'(OP_ST):   is_st_o   = 1'b1;
      OPCODE_W'(OP_JMP):  is_jmp_o  = 1'b1;
      OPCODE_W'(OP_BEQ):  is_beq_o  = 1'b1;
      OPCODE_W'(OP_HALT): is_halt_o = 1'b1;
      default: ;
    endcase
    legal_o = is_alu_o | is_ld_o | is_st_o | is_jmp_o | is_beq_o | is_halt_o;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bus timeout, illegal trap and HALT/resume.
// Every output is a register loaded with the value for the state being entered.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned OPCODE_W = OPCODE_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ALUOP_W  = ALUOP_W_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.master mem,
  input  logic                      zero_flag,
  input  logic                      resume,
  output logic [ALUOP_W-1:0]        alu_op,
  output logic                      reg_write,
  output logic                      mem_to_reg,
  output logic                      pc_inc,
  output logic                      pc_load,
  output logic [ADDR_W-1:0]         target,
  output logic                      halted,
  output logic                      illegal,
  output logic                      bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_sel_pc_q, mem_sel_pc_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [ALUOP_W-1:0]  alu_op_q, alu_op_d;
  logic                reg_write_q, reg_write_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic                pc_inc_q, pc_inc_d;
  logic                pc_load_q, pc_load_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;

  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   ir_addr;
  logic [ALUOP_W-1:0]  dec_alu_op;
  logic                is_alu, is_ld, is_st, is_jmp, is_beq, is_halt, legal;
  logic                ack_ok, timeout_hit;
  logic [CNT_W-1:0]    cnt_inc;
  logic                unused_ir;

  assign opcode    = ir_q[INSTR_W-1 -: OPCODE_W];
  assign ir_addr   = ir_q[ADDR_W-1:0];
  assign unused_ir = ^ir_q;

  multicycle_control_unit_decoder #(
    .OPCODE_W (OPCODE_W),
    .ALUOP_W  (ALUOP_W)
  ) u_decoder (
    .opcode_i  (opcode),
    .alu_op_o  (dec_alu_op),
    .is_alu_o  (is_alu),
    .is_ld_o   (is_ld),
    .is_st_o   (is_st),
    .is_jmp_o  (is_jmp),
    .is_beq_o  (is_beq),
    .is_halt_o (is_halt),
    .legal_o   (legal)
  );

  // An ack only counts while a request is actually on the bus.
  assign ack_ok      = mem_req_q & mem.mem_ack;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    cnt_d        = cnt_q;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    mem_sel_pc_d = 1'b0;
    mem_addr_d   = '0;
    alu_op_d     = '0;
    reg_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    pc_inc_d     = 1'b0;
    pc_load_d    = 1'b0;
    halted_d     = 1'b0;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    unique case (state_q)
      StFetch: begin
        if (ack_ok) begin
          ir_d    = mem.mem_rdata;
          state_d = StDecode;
        end else if (mem_req_q && timeout_hit) begin
          bus_err_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = StTrap;
        end else begin
          mem_req_d    = 1'b1;
          mem_sel_pc_d = 1'b1;
          if (mem_req_q) cnt_d = cnt_inc;
        end
      end
      StDecode: begin
        if (!legal) begin
          illegal_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = StTrap;
        end else begin
          // EXEC strobes; zero_flag is captured on the edge that enters EXEC.
          state_d     = StExec;
          alu_op_d    = dec_alu_op;
          reg_write_d = is_alu;
          pc_inc_d    = is_alu | (is_beq & ~zero_flag);
          pc_load_d   = is_jmp | (is_beq & zero_flag);
        end
      end
      StExec: begin
        cnt_d = '0;
        if (is_ld || is_st) begin
          state_d    = StMem;
          mem_req_d  = 1'b1;
          mem_we_d   = is_st;
          mem_addr_d = ir_addr;
        end else if (is_halt) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else begin
          state_d      = StFetch;
          mem_req_d    = 1'b1;
          mem_sel_pc_d = 1'b1;
        end
      end
      StMem: begin
        if (ack_ok) begin
          pc_inc_d = 1'b1;
          if (is_ld) begin
            state_d      = StWb;
            reg_write_d  = 1'b1;
            mem_to_reg_d = 1'b1;
          end else begin
            state_d      = StFetch;
            mem_req_d    = 1'b1;
            mem_sel_pc_d = 1'b1;
            cnt_d        = '0;
          end
        end else if (timeout_hit) begin
          bus_err_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = StTrap;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = is_st;
          mem_addr_d = ir_addr;
          cnt_d      = cnt_inc;
        end
      end
      StWb: begin
        state_d      = StFetch;
        mem_req_d    = 1'b1;
        mem_sel_pc_d = 1'b1;
        cnt_d        = '0;
      end
      StHalt: begin
        if (resume) begin
          state_d      = StFetch;
          pc_inc_d     = 1'b1;
          mem_req_d    = 1'b1;
          mem_sel_pc_d = 1'b1;
          cnt_d        = '0;
        end else begin
          halted_d = 1'b1;
        end
      end
      StTrap: halted_d = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      ir_q         <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_sel_pc_q <= 1'b0;
      mem_addr_q   <= '0;
      alu_op_q     <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_inc_q     <= 1'b0;
      pc_load_q    <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_sel_pc_q <= mem_sel_pc_d;
      mem_addr_q   <= mem_addr_d;
      alu_op_q     <= alu_op_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      pc_inc_q     <= pc_inc_d;
      pc_load_q    <= pc_load_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem.mem_req    = mem_req_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_sel_pc = mem_sel_pc_q;
  assign mem.mem_addr   = mem_addr_q;
  assign alu_op         = alu_op_q;
  assign reg_write      = reg_write_q;
  assign mem_to_reg     = mem_to_reg_q;
  assign pc_inc         = pc_inc_q;
  assign pc_load        = pc_load_q;
  assign target         = ir_addr;
  assign halted         = halted_q;
  assign illegal        = illegal_q;
  assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: instruction vector table plus timeout/trap/halt/reset cases.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       zero_flag;
  logic       resume;
  logic [3:0] alu_op;
  logic       reg_write, mem_to_reg, pc_inc, pc_load;
  logic [7:0] target;
  logic       halted, illegal, bus_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_unit_if #(.INSTR_W(16), .ADDR_W(8)) bus ();

  multicycle_control_unit #(
    .INSTR_W  (16),
    .OPCODE_W (4),
    .ADDR_W   (8),
    .ALUOP_W  (4),
    .TIMEOUT  (15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem        (bus),
    .zero_flag  (zero_flag),
    .resume     (resume),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .target     (target),
    .halted     (halted),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  typedef struct {
    logic [15:0] instr;
    logic        zero;
    int          fdly;
    int          mdly;
    logic [3:0]  alu;
    logic        rw;
    logic        inc;
    logic        ldpc;
    logic [7:0]  tgt;
    logic        is_mem;
    logic        we;
    logic        is_ld;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] snap();
    return {2'b00, bus.mem_req, bus.mem_we, bus.mem_sel_pc, bus.mem_addr, alu_op, reg_write,
            mem_to_reg, pc_inc, pc_load, target, halted, illegal, bus_err};
  endfunction

  task automatic do_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({name, " in reset"}, snap(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({name, " after release"}, snap(), 32'h0);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (bus.mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " req seen"}, {31'b0, bus.mem_req}, 32'h1);
  endtask

  // Acks in the (dly+1)-th cycle counted from the current one; returns one negedge after the ack.
  task automatic mem_xfer(input logic [15:0] data, input int dly);
    repeat (dly) @(negedge clk);
    bus.mem_rdata = data;
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic go_to_mem(input string name, input logic [15:0] instr);
    wait_req(name);
    mem_xfer(instr, 0);
    @(negedge clk);
    @(negedge clk);
    chk({name, " mem c1"}, {31'b0, bus.mem_req}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    zero_flag     = 1'b0;
    resume        = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    //            instr     z     fdly mdly alu  rw    inc   ldpc  tgt    mem   we    ld
    vecs[0] = '{16'h2011, 1'b0, 2, 0, 4'd2, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 1'b1, 0, 0, 4'd0, 1'b1, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h1ABC, 1'b0, 1, 0, 4'd1, 1'b1, 1'b1, 1'b0, 8'hBC, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h3F00, 1'b0, 3, 0, 4'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h6042, 1'b0, 0, 0, 4'd0, 1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h7020, 1'b1, 1, 0, 4'd0, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h7020, 1'b0, 0, 0, 4'd0, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h403C, 1'b0, 1, 1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{16'h5077, 1'b0, 0, 3, 4'd0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0};

    do_reset("por");

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      zero_flag = vecs[i].zero;
      wait_req(nm);
      chk({nm, " fetch"}, {30'b0, bus.mem_sel_pc, bus.mem_we}, 32'h2);
      mem_xfer(vecs[i].instr, vecs[i].fdly);
      chk({nm, " decode"}, {27'b0, bus.mem_req, reg_write, pc_inc, pc_load, mem_to_reg}, 32'h0);
      @(negedge clk);
      chk({nm, " exec"}, {alu_op, reg_write, mem_to_reg, pc_inc, pc_load, target},
          {vecs[i].alu, vecs[i].rw, 1'b0, vecs[i].inc, vecs[i].ldpc, vecs[i].tgt});
      @(negedge clk);
      if (!vecs[i].is_mem) begin
        chk({nm, " next fetch"}, {bus.mem_req, bus.mem_sel_pc, reg_write, pc_inc, pc_load},
            32'h18);
      end else begin
        chk({nm, " mem"}, {bus.mem_req, bus.mem_sel_pc, bus.mem_we, bus.mem_addr},
            {1'b1, 1'b0, vecs[i].we, vecs[i].tgt});
        mem_xfer(16'h0000, vecs[i].mdly);
        if (vecs[i].is_ld) begin
          chk({nm, " wb"}, {reg_write, mem_to_reg, pc_inc, pc_load, bus.mem_req}, 32'h1C);
          @(negedge clk);
          chk({nm, " next fetch"}, {bus.mem_req, bus.mem_sel_pc, reg_write, pc_inc, pc_load},
              32'h18);
        end else begin
          chk({nm, " st done"}, {pc_inc, reg_write, pc_load, bus.mem_req, bus.mem_sel_pc},
              32'h13);
        end
      end
    end
    zero_flag = 1'b0;

    // ST acked in the 15th request cycle: ack wins over the timeout.
    go_to_mem("to_ack", 16'h5010);
    repeat (14) @(negedge clk);
    chk("to_ack c15 req", {31'b0, bus.mem_req}, 32'h1);
    mem_xfer(16'h0000, 0);
    chk("to_ack no err", {28'b0, bus_err, halted, pc_inc, bus.mem_req}, 32'h3);

    // ST never acked: bus error after 15 waiting cycles.
    go_to_mem("to_err", 16'h5010);
    repeat (14) @(negedge clk);
    chk("to_err c15 req", {31'b0, bus.mem_req}, 32'h1);
    @(negedge clk);
    chk("to_err trap", {28'b0, bus.mem_req, bus_err, halted, illegal}, 32'h6);
    do_reset("after bus_err");

    // Undefined opcode traps and stays trapped even with resume.
    wait_req("ill");
    mem_xfer(16'h9000, 1);
    @(negedge clk);
    chk("ill trap", {25'b0, illegal, halted, bus_err, reg_write, pc_inc, pc_load, bus.mem_req},
        32'h60);
    repeat (5) @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("ill sticky", {28'b0, illegal, halted, bus.mem_req, pc_inc}, 32'hC);
    do_reset("after illegal");

    // HALT then resume after 5 halted cycles.
    wait_req("halt");
    mem_xfer(16'hF000, 0);
    @(negedge clk);
    chk("halt exec", {28'b0, reg_write, pc_inc, pc_load, halted}, 32'h0);
    @(negedge clk);
    chk("halt c1", {30'b0, halted, bus.mem_req}, 32'h2);
    repeat (4) @(negedge clk);
    chk("halt c5", {30'b0, halted, bus.mem_req}, 32'h2);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume", {28'b0, pc_inc, bus.mem_req, bus.mem_sel_pc, halted}, 32'hE);
    @(negedge clk);
    chk("resume pc_inc 1 cycle", {30'b0, pc_inc, bus.mem_req}, 32'h1);

    // Asynchronous reset in the middle of a MEM request.
    go_to_mem("rst_mem", 16'h4001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset mid-mem", snap(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post async reset", snap(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
